// File: rtl/snake_body_tracker_if.sv
// Handshake/bus bundle between the direction stage, snake_body_tracker and
// the renderer/apple logic. Clock and reset stay plain module ports.
interface snake_body_tracker_if #(
  parameter int GRID_W  = 16,
  parameter int GRID_H  = 12,
  parameter int MAX_LEN = 8
);
  localparam int X_W = $clog2(GRID_W);
  localparam int Y_W = $clog2(GRID_H);
  localparam int L_W = $clog2(MAX_LEN + 1);

  logic                   pause_clk;
  logic [1:0]             direction;
  logic                   grow;
  logic                   restart;
  logic [X_W-1:0]         head_x;
  logic [Y_W-1:0]         head_y;
  logic [MAX_LEN*X_W-1:0] body_x;
  logic [MAX_LEN*Y_W-1:0] body_y;
  logic [MAX_LEN-1:0]     body_valid;
  logic [L_W-1:0]         length;
  logic                   bad_collision;
  logic                   dead;

  modport slave (
    input  pause_clk, direction, grow, restart,
    output head_x, head_y, body_x, body_y, body_valid, length, bad_collision, dead
  );

  modport master (
    output pause_clk, direction, grow, restart,
    input  head_x, head_y, body_x, body_y, body_valid, length, bad_collision, dead
  );
endinterface

// File: rtl/snake_body_tracker.sv
// Snake head/body shift-register tracker with growth and wall/self collision.
// Optional SNAKE_WRAP_EN makes the walls wrap instead of killing the snake.
module snake_body_tracker #(
  parameter int GRID_W    = 16,
  parameter int GRID_H    = 12,
  parameter int MAX_LEN   = 8,
  parameter int START_X   = 4,
  parameter int START_Y   = 6,
  parameter int START_LEN = 3
) (
  input  logic                clk,
  input  logic                nrst,
  snake_body_tracker_if.slave bus
);
  localparam int X_W = $clog2(GRID_W);
  localparam int Y_W = $clog2(GRID_H);
  localparam int L_W = $clog2(MAX_LEN + 1);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;

  typedef enum logic {RUN = 1'b0, DEAD = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [X_W-1:0]     seg_x_q [MAX_LEN];
  logic [X_W-1:0]     seg_x_d [MAX_LEN];
  logic [Y_W-1:0]     seg_y_q [MAX_LEN];
  logic [Y_W-1:0]     seg_y_d [MAX_LEN];
  logic [L_W-1:0]     len_q, len_d;
  logic [MAX_LEN-1:0] valid_q, valid_d;
  logic               grow_pend_q, grow_pend_d;
  logic               bad_q, bad_d;

  logic               g, wall_edge, wall_hit, self_hit;
  logic [X_W-1:0]     nx;
  logic [Y_W-1:0]     ny;

  function automatic logic [X_W-1:0] start_x(int i);
    return (i < START_LEN) ? X_W'(START_X - i) : '0;
  endfunction

  function automatic logic [Y_W-1:0] start_y(int i);
    return (i < START_LEN) ? Y_W'(START_Y) : '0;
  endfunction

  function automatic logic [MAX_LEN-1:0] len_mask(logic [L_W-1:0] len);
    logic [MAX_LEN-1:0] m;
    for (int i = 0; i < MAX_LEN; i++) m[i] = (i < int'(len));
    return m;
  endfunction

  assign g = grow_pend_q | bus.grow;

  // Next head always wraps; the wall flag decides whether that wrap is legal.
  always_comb begin
    nx        = seg_x_q[0];
    ny        = seg_y_q[0];
    wall_edge = 1'b0;
    case (bus.direction)
      DIR_UP: begin
        wall_edge = (seg_y_q[0] == '0);
        ny = wall_edge ? Y_W'(GRID_H - 1) : seg_y_q[0] - 1'b1;
      end
      DIR_DOWN: begin
        wall_edge = (seg_y_q[0] == Y_W'(GRID_H - 1));
        ny = wall_edge ? '0 : seg_y_q[0] + 1'b1;
      end
      DIR_LEFT: begin
        wall_edge = (seg_x_q[0] == '0);
        nx = wall_edge ? X_W'(GRID_W - 1) : seg_x_q[0] - 1'b1;
      end
      default: begin
        wall_edge = (seg_x_q[0] == X_W'(GRID_W - 1));
        nx = wall_edge ? '0 : seg_x_q[0] + 1'b1;
      end
    endcase
`ifdef SNAKE_WRAP_EN
    wall_hit = 1'b0;
`else
    wall_hit = wall_edge;
`endif
  end

  // Without growth the tail cell is vacated this tick, so it is excluded.
  always_comb begin
    self_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if (((i < int'(len_q) - 1) || (g && (i < int'(len_q)))) &&
          (seg_x_q[i] == nx) && (seg_y_q[i] == ny))
        self_hit = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    seg_x_d     = seg_x_q;
    seg_y_d     = seg_y_q;
    len_d       = len_q;
    grow_pend_d = grow_pend_q | bus.grow;
    bad_d       = 1'b0;
    if (bus.restart) begin
      state_d     = RUN;
      grow_pend_d = 1'b0;
      len_d       = L_W'(START_LEN);
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_d[i] = start_x(i);
        seg_y_d[i] = start_y(i);
      end
    end else if (state_q == DEAD) begin
      grow_pend_d = 1'b0;
    end else if (bus.pause_clk) begin
      grow_pend_d = 1'b0;
      if (wall_hit || self_hit) begin
        bad_d   = 1'b1;
        state_d = DEAD;
      end else begin
        for (int i = 1; i < MAX_LEN; i++) begin
          seg_x_d[i] = seg_x_q[i-1];
          seg_y_d[i] = seg_y_q[i-1];
        end
        seg_x_d[0] = nx;
        seg_y_d[0] = ny;
        if (g && (len_q != L_W'(MAX_LEN))) len_d = len_q + 1'b1;
      end
    end
    valid_d = len_mask(len_d);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= RUN;
      len_q       <= L_W'(START_LEN);
      valid_q     <= len_mask(L_W'(START_LEN));
      grow_pend_q <= 1'b0;
      bad_q       <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= start_x(i);
        seg_y_q[i] <= start_y(i);
      end
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      valid_q     <= valid_d;
      grow_pend_q <= grow_pend_d;
      bad_q       <= bad_d;
      seg_x_q     <= seg_x_d;
      seg_y_q     <= seg_y_d;
    end
  end

  always_comb begin
    for (int i = 0; i < MAX_LEN; i++) begin
      bus.body_x[i*X_W +: X_W] = seg_x_q[i];
      bus.body_y[i*Y_W +: Y_W] = seg_y_q[i];
    end
  end

  assign bus.head_x        = seg_x_q[0];
  assign bus.head_y        = seg_y_q[0];
  assign bus.body_valid    = valid_q;
  assign bus.length        = len_q;
  assign bus.bad_collision = bad_q;
  assign bus.dead          = (state_q == DEAD);
endmodule

// File: tb/tb_snake_body_tracker.sv
// Directed bench for snake_body_tracker with default parameters.
module tb_snake_body_tracker;
  localparam logic [1:0] UP = 2'b00, DOWN = 2'b01, LEFT = 2'b10, RIGHT = 2'b11;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   total = 0;
  int   bad = 0;

  snake_body_tracker_if bus ();
  snake_body_tracker dut (.clk(clk), .nrst(nrst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_seg(input string tag, input int i, input int x, input int y);
    check({tag, "_x"}, 32'(bus.body_x[i*4 +: 4]), x);
    check({tag, "_y"}, 32'(bus.body_y[i*4 +: 4]), y);
  endtask

  task automatic check_head(input string tag, input int x, input int y);
    check({tag, "_hx"}, 32'(bus.head_x), x);
    check({tag, "_hy"}, 32'(bus.head_y), y);
  endtask

  task automatic tick(input logic [1:0] dir, input logic grw);
    bus.pause_clk = 1'b1;
    bus.direction = dir;
    bus.grow      = grw;
    @(posedge clk); #1;
    bus.pause_clk = 1'b0;
    bus.grow      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_restart();
    bus.restart = 1'b1;
    @(posedge clk); #1;
    bus.restart = 1'b0;
  endtask

  initial begin
    bus.pause_clk = 1'b0;
    bus.direction = RIGHT;
    bus.grow      = 1'b0;
    bus.restart   = 1'b0;
    #12;
    check_head("rst", 4, 6);
    check_seg("rst_s1", 1, 3, 6);
    check_seg("rst_s2", 2, 2, 6);
    check("rst_len", 32'(bus.length), 3);
    check("rst_valid", 32'(bus.body_valid), 32'h07);
    check("rst_dead", 32'(bus.dead), 0);
    check("rst_bad", 32'(bus.bad_collision), 0);
    nrst = 1'b1;
    idle(1);

    // Three RIGHT ticks, then idle cycles leave everything alone.
    repeat (3) tick(RIGHT, 1'b0);
    check_head("r3", 7, 6);
    check_seg("r3_s1", 1, 6, 6);
    check_seg("r3_s2", 2, 5, 6);
    check("r3_len", 32'(bus.length), 3);
    idle(3);
    check_head("r3_idle", 7, 6);

    // Restart wins over a same-cycle tick.
    bus.restart = 1'b1;
    tick(RIGHT, 1'b0);
    bus.restart = 1'b0;
    check_head("rs_tick", 4, 6);
    check("rs_tick_len", 32'(bus.length), 3);

    // Grow pulse on its own, consumed by the next tick.
    bus.grow = 1'b1;
    idle(1);
    bus.grow = 1'b0;
    check("gp_len_before", 32'(bus.length), 3);
    tick(RIGHT, 1'b0);
    check("g1_len", 32'(bus.length), 4);
    check_head("g1", 5, 6);
    check_seg("g1_tail", 3, 2, 6);
    check("g1_valid", 32'(bus.body_valid), 32'h0F);
    tick(RIGHT, 1'b0);
    check("g1_consumed", 32'(bus.length), 4);
    repeat (6) tick(RIGHT, 1'b1);
    check("gsat_len", 32'(bus.length), 8);
    check("gsat_valid", 32'(bus.body_valid), 32'hFF);
    check_head("gsat", 12, 6);
    check_seg("gsat_s7", 7, 5, 6);

    // Asynchronous reset between clock edges.
    nrst = 1'b0;
    #2;
    check_head("arst", 4, 6);
    check("arst_len", 32'(bus.length), 3);
    #1 nrst = 1'b1;
    idle(1);

    // Right wall.
    repeat (11) tick(RIGHT, 1'b0);
    check_head("wall_pre", 15, 6);
    check("wall_pre_bad", 32'(bus.bad_collision), 0);
    tick(RIGHT, 1'b0);
`ifdef SNAKE_WRAP_EN
    check_head("wrap", 0, 6);
    check("wrap_bad", 32'(bus.bad_collision), 0);
    check("wrap_dead", 32'(bus.dead), 0);
`else
    check("wall_bad", 32'(bus.bad_collision), 1);
    check("wall_dead", 32'(bus.dead), 1);
    check_head("wall", 15, 6);
    idle(1);
    check("wall_bad_gone", 32'(bus.bad_collision), 0);
    tick(RIGHT, 1'b1);
    tick(DOWN, 1'b0);
    check_head("dead_tick", 15, 6);
    check("dead_len", 32'(bus.length), 3);
    check("dead_still", 32'(bus.dead), 1);
    check("dead_bad", 32'(bus.bad_collision), 0);
`endif
    do_restart();
    check_head("restart", 4, 6);
    check("restart_dead", 32'(bus.dead), 0);
    check("restart_len", 32'(bus.length), 3);

    // Self collision after growing to five and turning back on the body.
    tick(RIGHT, 1'b1);
    tick(RIGHT, 1'b1);
    check("self_len", 32'(bus.length), 5);
    tick(DOWN, 1'b0);
    check_head("self_d", 6, 7);
    tick(LEFT, 1'b0);
    check_head("self_l", 5, 7);
    check("self_l_bad", 32'(bus.bad_collision), 0);
    tick(UP, 1'b0);
    check("self_bad", 32'(bus.bad_collision), 1);
    check("self_dead", 32'(bus.dead), 1);
    check_head("self", 5, 7);
    check("self_len_frz", 32'(bus.length), 5);

    // Reversal hits segment 1.
    do_restart();
    tick(LEFT, 1'b0);
    check("rev_bad", 32'(bus.bad_collision), 1);
    check_head("rev", 4, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/snake_body_tracker.md
# snake_body_tracker

Consumes the registered 2-bit direction produced by the button/direction stage and advances the snake on every game tick. It maintains the head coordinate and a shift-register history of body segments, and handles growth requests. It detects wall and self collisions and returns `bad_collision` to the direction stage, which re-arms the direction to RIGHT. It sits between the direction logic and the renderer/apple logic.

## Interface
- `GRID_W`, 16, grid columns; X_W = $clog2(GRID_W)
- `GRID_H`, 12, grid rows; Y_W = $clog2(GRID_H)
- `MAX_LEN`, 8, maximum segments including head; L_W = $clog2(MAX_LEN+1)
- `START_X`, 4, head start column; must satisfy START_X >= START_LEN-1
- `START_Y`, 6, head start row
- `START_LEN`, 3, initial length, 1..MAX_LEN

Ports:
- `clk`  in  1  system clock
- `nrst`  in  1  asynchronous, active-low reset
- `pause_clk`  in  1  game-tick strobe, one `clk` cycle wide
- `direction`  in  2  UP=00, DOWN=01, LEFT=10, RIGHT=11
- `grow`  in  1  apple-eaten pulse
- `restart`  in  1  reinitialise the snake
- `head_x`  out  X_W  segment 0 column
- `head_y`  out  Y_W  segment 0 row
- `body_x`  out  MAX_LEN*X_W  segment i column at [i*X_W +: X_W]
- `body_y`  out  MAX_LEN*Y_W  segment i row at [i*Y_W +: Y_W]
- `body_valid`  out  MAX_LEN  bit i = 1 when i < length
- `length`  out  L_W  current segment count
- `bad_collision`  out  1  one-cycle pulse on a collision tick
- `dead`  out  1  high in DEAD state

## Operation
- Start image, applied on reset and on restart:
  - segment i = (START_X-i, START_Y) for i < START_LEN; other segments (0,0)
  - length = START_LEN
  - state RUN; grow_pending = 0; bad_collision = 0
- FSM states: RUN, DEAD.
  - RUN→DEAD on a collision tick.
  - DEAD→RUN only via `restart`.
- grow_pending: set by `grow` in any cycle. Cleared by the next RUN tick, which consumes it.
- RUN tick (`pause_clk`=1):
  - next head = head + delta: UP y-1, DOWN y+1, LEFT x-1, RIGHT x+1.
  - g = grow_pending OR `grow` in the same cycle.
  - Wall collision: x==0 & LEFT, x==GRID_W-1 & RIGHT, y==0 & UP, or y==GRID_H-1 & DOWN.
  - Self collision: next head equals segment i (valid) for i in 1..length-2 when g=0, or 1..length-1 when g=1. Moving into the cell the tail is vacating is legal.
  - A direct reversal hits segment 1 and is a self collision (the direction stage prevents it).
  - On no collision: segment[i] ← segment[i-1] for i ≥ 1; segment[0] ← next head; length ← min(length+g, MAX_LEN).
    - Growth at MAX_LEN is discarded; grow_pending is still cleared.
  - On collision: segments and length are frozen, `bad_collision` pulses, state → DEAD.
- DEAD: ticks and grow have no effect on position. grow_pending is cleared.
- `restart` is honoured in any state and wins over a same-cycle tick.
- Segments at index ≥ length hold stale data. Consumers use `body_valid`.

## Timing
- All outputs are registered. No combinational input-to-output path.
- A tick sampled on edge N updates position and length visible after edge N (latency 1).
- `bad_collision` is high for exactly the one cycle after the collision edge. `dead` rises on the same edge.
- `restart` sampled on edge N loads the start image after edge N.
- `nrst` low loads the start image immediately, asynchronously, including mid-tick.

## Configuration
- `SNAKE_WRAP_EN`
  - Defined: walls wrap. x: GRID_W-1 → 0 and 0 → GRID_W-1; y likewise with GRID_H. Wall collision never occurs; self collision is unchanged.
  - Undefined: wall collision as described in Operation.

## Test plan
All scenarios use default parameters.
- Reset → head (4,6); segments 1 and 2 = (3,6), (2,6); length 3; body_valid 8'b0000_0111; dead 0; bad_collision 0.
- Direction RIGHT, 3 ticks → head (7,6); segments (6,6), (5,6); length 3. No change on cycles without a tick.
- `grow` pulse, then a RIGHT tick → length 4; head (5,6); tail (2,6) retained. 6 further grow+tick pairs → length saturates at 8 and body_valid = 8'hFF.
- RIGHT ticks until head x=15, then one more tick → bad_collision high 1 cycle; dead 1; head stays (15,6). Further ticks change nothing. `restart` → start image and dead 0.
- Two grow+RIGHT ticks (length 5), then DOWN, LEFT, UP ticks → third tick targets (5,6) = segment 3 → collision and DEAD.
- With SNAKE_WRAP_EN defined: head (15,6) + RIGHT tick → head (0,6), no bad_collision.
